// File: rtl/threshold_cal_ctrl.sv
// Cutoff configuration, per-frame mask counting and y-cutoff auto-calibration
// for the YCrCb threshold stage. Host writes are shadowed and committed at frame starts.
module threshold_cal_ctrl #(
   parameter int COUNT_WIDTH   = 17,
   parameter int TARGET_LO     = 2000,
   parameter int TARGET_HI     = 6000,
   parameter int Y_STEP        = 4,
   parameter int MAX_CAL_ITERS = 32,
   parameter int Y_RST         = 128,
   parameter int CR_RST        = 160,
   parameter int CB_RST        = 160
) (
   input  logic                   clk_in,
   input  logic                   rst_in,
   input  logic                   cfg_valid_in,
   input  logic [1:0]             cfg_addr_in,
   input  logic [7:0]             cfg_data_in,
   output logic                   cfg_ready_out,
   input  logic                   new_frame_in,
   input  logic                   mask_valid_in,
   input  logic                   mask_in,
   input  logic                   cal_start_in,
   output logic [7:0]             y_cutoff_out,
   output logic [7:0]             cr_cutoff_out,
   output logic [7:0]             cb_cutoff_out,
   output logic [COUNT_WIDTH-1:0] mask_count_out,
   output logic                   cal_busy_out,
   output logic                   cal_done_out,
   output logic                   cal_ok_out
);
   // state    | meaning
   // IDLE     | host writes allowed, waiting for cal_start_in
   // SETTLE   | discard the frame following a cutoff change
   // MEASURE  | count the frame used for the decision
   // ADJUST   | compare count to band, step y cutoff
   // DONE     | report result, pulse cal_done_out
   typedef enum logic [2:0] {IDLE, SETTLE, MEASURE, ADJUST, DONE} state_t;

   localparam int                     ITER_W    = (MAX_CAL_ITERS > 1) ? $clog2(MAX_CAL_ITERS) : 1;
   localparam logic [ITER_W-1:0]      ITER_LAST = ITER_W'(MAX_CAL_ITERS - 1);
   localparam logic [ITER_W-1:0]      ITER_ONE  = ITER_W'(1);
   localparam logic [7:0]             Y_STEP_B  = 8'(Y_STEP);
   localparam logic [31:0]            LO_B      = 32'(TARGET_LO);
   localparam logic [31:0]            HI_B      = 32'(TARGET_HI);
   localparam logic [COUNT_WIDTH-1:0] CNT_MAX   = '1;
   localparam logic [COUNT_WIDTH-1:0] CNT_ONE   = COUNT_WIDTH'(1);

   state_t                 state_q, state_d;
   logic [7:0]             y_q, y_d, cr_q, cr_d, cb_q, cb_d;
   logic [7:0]             y_sh_q, y_sh_d, cr_sh_q, cr_sh_d, cb_sh_q, cb_sh_d;
   logic                   pending_q, pending_d;
   logic [COUNT_WIDTH-1:0] cnt_q, cnt_d, mask_count_q, mask_count_d;
   logic [ITER_W-1:0]      iter_q, iter_d;
   logic                   busy_q, busy_d, done_q, done_d, ok_q, ok_d, ready_q, ready_d;

   logic [COUNT_WIDTH-1:0] cnt_inc;
   logic [31:0]            count_ext;
   logic [7:0]             y_up, y_dn, y_next;
   logic                   at_limit;

   always_comb begin
      cnt_inc   = cnt_q;
      count_ext = 32'(mask_count_q);
      y_up      = (y_q > (8'd255 - Y_STEP_B)) ? 8'd255 : (y_q + Y_STEP_B);
      y_dn      = (y_q < Y_STEP_B) ? 8'd0 : (y_q - Y_STEP_B);
      y_next    = y_q;
      at_limit  = 1'b0;

      state_d      = state_q;
      y_d          = y_q;
      cr_d         = cr_q;
      cb_d         = cb_q;
      y_sh_d       = y_sh_q;
      cr_sh_d      = cr_sh_q;
      cb_sh_d      = cb_sh_q;
      pending_d    = pending_q;
      cnt_d        = cnt_q;
      mask_count_d = mask_count_q;
      iter_d       = iter_q;
      ok_d         = ok_q;

      if (mask_valid_in && mask_in && (cnt_q != CNT_MAX)) begin
         cnt_inc = cnt_q + CNT_ONE;
      end

      if (new_frame_in) begin
         mask_count_d = cnt_inc;
         cnt_d        = '0;
      end else begin
         cnt_d = cnt_inc;
      end

      // Commit uses the pre-write shadow so a same-cycle write waits a frame.
      if (new_frame_in && pending_q) begin
         y_d       = y_sh_q;
         cr_d      = cr_sh_q;
         cb_d      = cb_sh_q;
         pending_d = 1'b0;
      end

      if (cfg_valid_in && ready_q) begin
         case (cfg_addr_in)
            2'd0: begin y_sh_d  = cfg_data_in; pending_d = 1'b1; end
            2'd1: begin cr_sh_d = cfg_data_in; pending_d = 1'b1; end
            2'd2: begin cb_sh_d = cfg_data_in; pending_d = 1'b1; end
            default: ;
         endcase
      end

      case (state_q)
         IDLE: begin
            if (cal_start_in) begin
               state_d = SETTLE;
               iter_d  = '0;
               ok_d    = 1'b0;
            end
         end
         SETTLE:  if (new_frame_in) state_d = MEASURE;
         MEASURE: if (new_frame_in) state_d = ADJUST;
         ADJUST: begin
            // mask_count_q was loaded from the measured frame on entry here.
            if ((count_ext >= LO_B) && (count_ext <= HI_B)) begin
               ok_d    = 1'b1;
               state_d = DONE;
            end else begin
               if (count_ext > HI_B) begin
                  y_next   = y_up;
                  at_limit = (y_q == 8'd255);
               end else begin
                  y_next   = y_dn;
                  at_limit = (y_q == 8'd0);
               end
               y_d    = y_next;
               y_sh_d = y_next;
               if (at_limit || (iter_q == ITER_LAST)) begin
                  ok_d    = 1'b0;
                  state_d = DONE;
               end else begin
                  iter_d  = iter_q + ITER_ONE;
                  state_d = SETTLE;
               end
            end
         end
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase

      busy_d  = (state_d == SETTLE) || (state_d == MEASURE) || (state_d == ADJUST);
      done_d  = (state_d == DONE);
      ready_d = !busy_d;
   end

   always_ff @(posedge clk_in) begin
      if (!rst_in) begin
         state_q      <= IDLE;
         y_q          <= 8'(Y_RST);
         cr_q         <= 8'(CR_RST);
         cb_q         <= 8'(CB_RST);
         y_sh_q       <= 8'(Y_RST);
         cr_sh_q      <= 8'(CR_RST);
         cb_sh_q      <= 8'(CB_RST);
         pending_q    <= 1'b0;
         cnt_q        <= '0;
         mask_count_q <= '0;
         iter_q       <= '0;
         busy_q       <= 1'b0;
         done_q       <= 1'b0;
         ok_q         <= 1'b0;
         ready_q      <= 1'b1;
      end else begin
         state_q      <= state_d;
         y_q          <= y_d;
         cr_q         <= cr_d;
         cb_q         <= cb_d;
         y_sh_q       <= y_sh_d;
         cr_sh_q      <= cr_sh_d;
         cb_sh_q      <= cb_sh_d;
         pending_q    <= pending_d;
         cnt_q        <= cnt_d;
         mask_count_q <= mask_count_d;
         iter_q       <= iter_d;
         busy_q       <= busy_d;
         done_q       <= done_d;
         ok_q         <= ok_d;
         ready_q      <= ready_d;
      end
   end

   assign y_cutoff_out   = y_q;
   assign cr_cutoff_out  = cr_q;
   assign cb_cutoff_out  = cb_q;
   assign mask_count_out = mask_count_q;
   assign cal_busy_out   = busy_q;
   assign cal_done_out   = done_q;
   assign cal_ok_out     = ok_q;
   assign cfg_ready_out  = ready_q;

endmodule
